frame_capture: RTL and testbench
================================

// Module: frame_capture
// PURPOSE
//  Receiving end of the thresholder pixel stream: accepts one raster-order pixel per
//  clock (row-major, col fastest) under valid/ready, writes it into an internal
//  SIZE x SIZE frame buffer and signals frame completion. Buffer is read back through
//  a registered random-access port (display/VGA side or testbench dump).
// PARAMETERS
//  SIZE   10  frame width and height in pixels (square frame), 2..255
//  PIX_W  8   pixel width in bits
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      1-cycle pulse: arm capture of a new frame
//  pix_in      in   PIX_W  incoming pixel (0 or 255 from thresholder, any value legal)
//  pix_valid   in   1      pix_in valid this cycle
//  pix_ready   out  1      block can accept a pixel this cycle
//  busy        out  1      high while in CAPTURE
//  frame_done  out  1      1-cycle pulse after last pixel written
//  frame_valid out  1      buffer holds a complete frame
//  rd_row      in   8      read row address
//  rd_col      in   8      read column address
//  rd_data     out  PIX_W  registered read data
// BEHAVIOUR
//  - Reset: state IDLE; row=col=0; pix_ready, busy, frame_done, frame_valid, rd_data = 0.
//    Buffer contents are not reset. Reset mid-frame aborts capture immediately.
//  - States: IDLE -> CAPTURE on start; CAPTURE -> DONE on accept of pixel (SIZE-1,SIZE-1);
//    DONE -> CAPTURE on start. No other transitions.
//  - pix_ready = 1 exactly in CAPTURE (registered-state decode, no comb path from pix_valid).
//  - Accept = pix_valid & pix_ready: mem[row][col] <= pix_in; col wraps SIZE-1 -> 0 with
//    row+1; no change to row/col when not accepted (stalls of any length are legal).
//  - Last accept: next cycle state=DONE, frame_done=1 for exactly one cycle, frame_valid=1.
//  - start in CAPTURE: restart at (0,0), pixel accepted that same cycle is discarded;
//    frame_valid stays 0. start in DONE: frame_valid -> 0, row=col=0, state CAPTURE.
//  - start in IDLE/DONE same cycle as pix_valid: pixel ignored (pix_ready was 0).
//  - frame_valid cleared only by start or rst; pixels presented in IDLE/DONE are ignored.
//  - Read: rd_data <= mem[rd_row][rd_col] on every clock, 1-cycle latency, any state.
//    rd_row>=SIZE or rd_col>=SIZE -> rd_data <= 0. Read of the address being written in
//    the same cycle returns the old value.
//  - Counters 8 bits; SIZE limit guarantees no overflow.
// CONFIGURATION
//  FRAME_CAPTURE_STATS_EN defined: extra output white_count [15:0] = number of pixels
//   accepted in the current frame with pix_in == {PIX_W{1'b1}}; cleared to 0 by rst and
//   by start, increments on the accept cycle (visible next cycle), held in DONE.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1. rst=1 mid-stream -> all outputs 0 next edge, pix_ready=0, state IDLE.
//  2. start, stream 100 pixels pix_in=row*10+col with pix_valid=1 -> frame_done pulse one
//     cycle after 100th accept; rd_row=3,rd_col=7 -> rd_data=37 one cycle later.
//  3. Same stream with pix_valid toggling 1/0 every cycle -> identical buffer, frame_done
//     after 199 cycles of CAPTURE, exactly one pulse.
//  4. start again after 42 accepts, then full frame of 0xAA -> every location reads 0xAA,
//     frame_valid=0 until new frame_done.
//  5. rd_row=10, rd_col=0 and rd_row=0, rd_col=255 -> rd_data=0.
//  6. STATS_EN: frame with 37 pixels =255, rest 0 -> white_count=37 at frame_done;
//     next start -> white_count=0.

Source files
------------

// File: rtl/frame_capture.sv
// frame_capture: raster-order pixel sink into a SIZE x SIZE buffer with a registered read port.
// Optional macro FRAME_CAPTURE_STATS_EN adds white_count (all-ones pixels accepted this frame).
module frame_capture #(
  parameter int SIZE  = 10,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_valid,
  input  logic [7:0]       rd_row,
  input  logic [7:0]       rd_col,
`ifdef FRAME_CAPTURE_STATS_EN
  output logic [15:0]      white_count,
`endif
  output logic [PIX_W-1:0] rd_data
);

  localparam int DEPTH = SIZE * SIZE;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] LAST  = 8'(SIZE - 1);
  localparam logic [7:0] LIMIT = 8'(SIZE);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_row;
  logic [7:0]       r_col;
  logic             w_accept;
  logic             w_lastAccept;
  logic [AW-1:0]    w_wrAddr;
  logic [AW-1:0]    w_rdAddr;
  logic             w_rdInRange;
  logic [PIX_W-1:0] r_mem [0:(1<<AW)-1];

  // Buffer is flattened row-major; row/col never exceed SIZE-1 when used, so AW bits suffice.
  assign w_wrAddr    = AW'(r_row) * AW'(SIZE) + AW'(r_col);
  assign w_rdAddr    = AW'(rd_row) * AW'(SIZE) + AW'(rd_col);
  assign w_rdInRange = (rd_row < LIMIT) && (rd_col < LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // A start in CAPTURE wins over a simultaneous pixel, so that pixel is dropped.
  always_comb begin
    w_nextState  = r_state;
    pix_ready    = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    w_lastAccept = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = CAPTURE;
      end
      CAPTURE: begin
        pix_ready    = 1'b1;
        busy         = 1'b1;
        w_accept     = pix_valid & ~start;
        w_lastAccept = w_accept && (r_row == LAST) && (r_col == LAST);
        if (w_lastAccept) w_nextState = DONE;
      end
      DONE: begin
        if (start) w_nextState = CAPTURE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row       <= 8'd0;
      r_col       <= 8'd0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_done <= w_lastAccept;
      if (start) begin
        r_row       <= 8'd0;
        r_col       <= 8'd0;
        frame_valid <= 1'b0;
      end else if (w_accept) begin
        if (w_lastAccept) frame_valid <= 1'b1;
        if (r_col == LAST) begin
          r_col <= 8'd0;
          r_row <= r_row + 8'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[w_wrAddr] <= pix_in;
  end

  // Read sees the pre-write contents when it hits the location being written this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              rd_data <= '0;
    else if (w_rdInRange) rd_data <= r_mem[w_rdAddr];
    else                  rd_data <= '0;
  end

`ifdef FRAME_CAPTURE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      white_count <= 16'd0;
    else if (start)                               white_count <= 16'd0;
    else if (w_accept && (pix_in == {PIX_W{1'b1}})) white_count <= white_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: randomized self-checking bench for frame_capture against a frame-level model.
// Exercises the white_count output when FRAME_CAPTURE_STATS_EN is defined.
module tb_frame_capture;

  localparam int SIZE  = 10;
  localparam int PIX_W = 8;
  localparam int NPIX  = SIZE * SIZE;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic [7:0] rd_row;
  logic [7:0] rd_col;
  logic       pix_ready;
  logic       busy;
  logic       frame_done;
  logic       frame_valid;
  logic [7:0] rd_data;
`ifdef FRAME_CAPTURE_STATS_EN
  logic [15:0] white_count;
`endif

  int checks = 0;
  int failures = 0;

  // Frame-level model: a pixel store filled in raster order plus a few status flags.
  logic [7:0] expMem [SIZE][SIZE];
  bit         expCapturing;
  bit         expFrameValid;
  bit         expDone;
  int         expK;
  int         expWhite;

  always #5 clk = ~clk;

  frame_capture #(.SIZE(SIZE), .PIX_W(PIX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_valid(frame_valid),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
`ifdef FRAME_CAPTURE_STATS_EN
    .white_count(white_count),
`endif
    .rd_data    (rd_data)
  );

  task automatic modelReset();
    expCapturing  = 1'b0;
    expFrameValid = 1'b0;
    expDone       = 1'b0;
    expK          = 0;
    expWhite      = 0;
  endtask

  function automatic logic [7:0] expRead(input logic [7:0] r, input logic [7:0] c);
    if (r < SIZE && c < SIZE) return expMem[r][c];
    return 8'd0;
  endfunction

  // Drive one clock of stimulus, then advance the model by the same clock.
  task automatic cycle(input logic s, input logic v, input logic [7:0] p);
    start = s;
    pix_valid = v;
    pix_in = p;
    @(posedge clk);
    #1;
    expDone = 1'b0;
    if (s) begin
      expCapturing  = 1'b1;
      expFrameValid = 1'b0;
      expK          = 0;
      expWhite      = 0;
    end else if (v && expCapturing) begin
      expMem[expK / SIZE][expK % SIZE] = p;
      if (p == 8'hFF) expWhite++;
      expK++;
      if (expK == NPIX) begin
        expCapturing  = 1'b0;
        expFrameValid = 1'b1;
        expDone       = 1'b1;
      end
    end
  endtask

  task automatic readAt(input logic [7:0] r, input logic [7:0] c, output logic [7:0] d);
    rd_row = r;
    rd_col = c;
    cycle(1'b0, 1'b0, 8'h00);
    d = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = 8'h00;
    rd_row = 8'hFF; rd_col = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    cycle(1'b0, 1'b0, 8'h00);
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%0b exp=0", pix_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_fvalid got=%0b exp=0", frame_valid); end
    rd_row = 8'd0; rd_col = 8'd0;
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 23; i++) cycle(1'b0, 1'b1, 8'($urandom_range(1, 255)));
    checks++; if (busy !== expCapturing) begin failures++; $display("[TB] FAIL midframe_busy got=%0b exp=%0b", busy, expCapturing); end
    checks++; if (rd_data !== expMem[0][0]) begin failures++; $display("[TB] FAIL midframe_read got=%0h exp=%0h", rd_data, expMem[0][0]); end
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("[TB] FAIL async_ready got=%0b exp=0", pix_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL async_busy got=%0b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL async_fdone got=%0b exp=0", frame_done); end
    checks++; if (rd_data !== 8'd0) begin failures++; $display("[TB] FAIL async_rddata got=%0h exp=0", rd_data); end
`ifdef FRAME_CAPTURE_STATS_EN
    checks++; if (white_count !== 16'd0) begin failures++; $display("[TB] FAIL async_white got=%0d exp=0", white_count); end
`endif
    cycle(1'b0, 1'b1, 8'h55);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'h55);
      checks++; if (pix_ready !== 1'b0 || frame_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL idle_ignore ready=%0b fvalid=%0b exp 0/0", pix_ready, frame_valid);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] d;
    rd_row = 8'd3; rd_col = 8'd7;
    cycle(1'b1, 1'b0, 8'h00);
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready got=%0b exp=1", pix_ready); end
    for (int i = 0; i < NPIX; i++) begin
      cycle(1'b0, 1'b1, 8'((i / SIZE) * 10 + (i % SIZE)));
      checks++; if (frame_done !== expDone) begin
        failures++; $display("[TB] FAIL full_done_%0d got=%0b exp=%0b", i, frame_done, expDone);
      end
    end
    checks++; if (frame_done !== 1'b1 || frame_valid !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL full_end done=%0b fvalid=%0b busy=%0b exp 1/1/0", frame_done, frame_valid, busy);
    end
    readAt(8'd3, 8'd7, d);
    checks++; if (d !== 8'd37) begin failures++; $display("[TB] FAIL full_read37 got=%0d exp=37", d); end
    checks++; if (frame_done !== 1'b0 || frame_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL full_pulse done=%0b fvalid=%0b exp 0/1", frame_done, frame_valid);
    end
  endtask

  task automatic test_toggle_valid();
    int doneCycle;
    int pulses;
    logic v;
    logic [7:0] d;
    doneCycle = -1;
    pulses = 0;
    cycle(1'b1, 1'b0, 8'h00);
    for (int n = 1; n <= 400 && doneCycle < 0; n++) begin
      v = n[0];
      cycle(1'b0, v, v ? 8'(expK) : 8'($urandom_range(0, 255)));
      checks++; if (frame_done !== expDone) begin
        failures++; $display("[TB] FAIL toggle_done_%0d got=%0b exp=%0b", n, frame_done, expDone);
      end
      if (frame_done === 1'b1) begin doneCycle = n; pulses++; end
    end
    checks++; if (doneCycle !== 199) begin failures++; $display("[TB] FAIL toggle_latency got=%0d exp=199", doneCycle); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'hEE);
      if (frame_done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL toggle_pulses got=%0d exp=1", pulses); end
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        readAt(8'(r), 8'(c), d);
        checks++; if (d !== 8'(r * 10 + c)) begin
          failures++; $display("[TB] FAIL toggle_dump_%0d_%0d got=%0d exp=%0d", r, c, d, r * 10 + c);
        end
      end
    end
  endtask

  task automatic test_restart();
    logic [7:0] d;
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("[TB] FAIL restart_pre got=%0b exp=1", frame_valid); end
    cycle(1'b1, 1'b1, 8'h11);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("[TB] FAIL restart_clear got=%0b exp=0", frame_valid); end
    for (int i = 0; i < 42; i++) cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    cycle(1'b1, 1'b1, 8'h33);
    for (int i = 0; i < NPIX; i++) begin
      cycle(1'b0, 1'b1, 8'hAA);
      checks++; if (frame_valid !== expFrameValid || frame_done !== expDone) begin
        failures++; $display("[TB] FAIL restart_flags_%0d fvalid=%0b done=%0b exp %0b/%0b", i, frame_valid, frame_done, expFrameValid, expDone);
      end
    end
    checks++; if (frame_done !== 1'b1) begin failures++; $display("[TB] FAIL restart_done got=%0b exp=1", frame_done); end
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        readAt(8'(r), 8'(c), d);
        checks++; if (d !== 8'hAA) begin failures++; $display("[TB] FAIL restart_dump_%0d_%0d got=%0h exp=aa", r, c, d); end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] d;
    logic [7:0] addrs [6][2];
    logic [7:0] exps [6];
    addrs[0] = '{8'd10, 8'd0};   exps[0] = 8'h00;
    addrs[1] = '{8'd0, 8'd255};  exps[1] = 8'h00;
    addrs[2] = '{8'd9, 8'd10};   exps[2] = 8'h00;
    addrs[3] = '{8'd255, 8'd255}; exps[3] = 8'h00;
    addrs[4] = '{8'd9, 8'd9};    exps[4] = 8'hAA;
    addrs[5] = '{8'd0, 8'd0};    exps[5] = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      readAt(addrs[i][0], addrs[i][1], d);
      checks++; if (d !== exps[i]) begin
        failures++; $display("[TB] FAIL range_%0d_%0d got=%0h exp=%0h", addrs[i][0], addrs[i][1], d, exps[i]);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] expRd;
    logic [7:0] p;
    logic v;
    bit finished;
    finished = 1'b0;
    cycle(1'b1, 1'b0, 8'h00);
    for (int n = 0; n < 3000 && !finished; n++) begin
      if ($urandom_range(0, 1) == 0 && expCapturing) begin
        rd_row = 8'(expK / SIZE);
        rd_col = 8'(expK % SIZE);
      end else begin
        rd_row = 8'($urandom_range(0, 11));
        rd_col = 8'($urandom_range(0, 11));
      end
      expRd = expRead(rd_row, rd_col);
      v = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 2))
        0:       p = 8'h00;
        1:       p = 8'hFF;
        default: p = 8'($urandom_range(0, 255));
      endcase
      cycle(1'b0, v, p);
      checks++; if (rd_data !== expRd || frame_done !== expDone || pix_ready !== expCapturing) begin
        failures++; $display("[TB] FAIL random_%0d rd=%0h done=%0b ready=%0b exp %0h/%0b/%0b", n, rd_data, frame_done, pix_ready, expRd, expDone, expCapturing);
      end
      if (expDone) finished = 1'b1;
    end
    checks++; if (!finished) begin failures++; $display("[TB] FAIL random_timeout got=%0d accepts exp=%0d", expK, NPIX); end
  endtask

`ifdef FRAME_CAPTURE_STATS_EN
  task automatic test_stats();
    bit white [NPIX];
    int marked;
    int idx;
    logic v;
    marked = 0;
    for (int i = 0; i < NPIX; i++) white[i] = 1'b0;
    while (marked < 37) begin
      idx = $urandom_range(0, NPIX - 1);
      if (!white[idx]) begin white[idx] = 1'b1; marked++; end
    end
    cycle(1'b1, 1'b0, 8'h00);
    for (int n = 0; n < 2000 && expCapturing; n++) begin
      v = ($urandom_range(0, 3) != 0);
      cycle(1'b0, v, white[expK] ? 8'hFF : 8'h00);
      checks++; if (white_count !== 16'(expWhite)) begin
        failures++; $display("[TB] FAIL stats_run_%0d got=%0d exp=%0d", n, white_count, expWhite);
      end
    end
    checks++; if (frame_done !== 1'b1 || white_count !== 16'd37) begin
      failures++; $display("[TB] FAIL stats_done done=%0b white=%0d exp 1/37", frame_done, white_count);
    end
    cycle(1'b0, 1'b1, 8'hFF);
    checks++; if (white_count !== 16'd37) begin failures++; $display("[TB] FAIL stats_hold got=%0d exp=37", white_count); end
    cycle(1'b1, 1'b1, 8'hFF);
    checks++; if (white_count !== 16'd0) begin failures++; $display("[TB] FAIL stats_clear got=%0d exp=0", white_count); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_toggle_valid();
    test_restart();
    test_out_of_range();
    test_random_stream();
`ifdef FRAME_CAPTURE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
